// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that multiplexes several one-deep byte mailboxes onto a
// single uart_tx, sending each mailbox as a {4'hA, src_id} header plus payload.
module uart_tx_scheduler #(
   parameter int NUM_SRC     = 3,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     src_valid,
   input  logic [8*NUM_SRC-1:0]   src_data,
   output logic [NUM_SRC-1:0]     src_pending,
   input  logic                   tx_busy,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   output logic                   sched_busy,
   output logic                   frame_done,
   output logic [NUM_SRC-1:0]     overwrite,
   output logic                   ack_error
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      H_START = 3'd1,
      H_ACK   = 3'd2,
      H_DONE  = 3'd3,
      P_START = 3'd4,
      P_ACK   = 3'd5,
      P_DONE  = 3'd6
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [7:0]         mailbox [NUM_SRC];
   logic [7:0]         frame_data;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_next;
   logic [PTR_W-1:0]   grant;
   logic               grant_found;
   logic               grant_fire;
   logic               ack_timeout;
   logic               load_payload;
   logic [CNT_W-1:0]   ack_cnt;

   function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      return PTR_W'(s);
   endfunction

   // First pending mailbox at or after rr_ptr, searching cyclically.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!grant_found && src_pending[wrap_idx(int'(rr_ptr), k)]) begin
            grant       = wrap_idx(int'(rr_ptr), k);
            grant_found = 1'b1;
         end
      end
   end

   assign rr_next    = (grant == PTR_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
   assign sched_busy = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      tx_start     = 1'b0;
      frame_done   = 1'b0;
      grant_fire   = 1'b0;
      ack_timeout  = 1'b0;
      load_payload = 1'b0;
      case (state)
         IDLE: begin
            if (!tx_busy && grant_found) begin
               grant_fire = 1'b1;
               state_next = H_START;
            end
         end
         H_START: begin
            tx_start   = 1'b1;
            state_next = H_ACK;
         end
         H_ACK: begin
            if (tx_busy) begin
               state_next = H_DONE;
            end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               ack_timeout = 1'b1;
               state_next  = IDLE;
            end
         end
         H_DONE: begin
            if (!tx_busy) begin
               load_payload = 1'b1;
               state_next   = P_START;
            end
         end
         P_START: begin
            tx_start   = 1'b1;
            state_next = P_ACK;
         end
         P_ACK: begin
            if (tx_busy) begin
               state_next = P_DONE;
            end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               ack_timeout = 1'b1;
               state_next  = IDLE;
            end
         end
         P_DONE: begin
            if (!tx_busy) begin
               frame_done = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Mailboxes: a capture in the grant cycle keeps the new byte pending while
   // the frame register takes the old one.
   always_ff @(posedge clock) begin
      if (reset) begin
         src_pending <= '0;
         overwrite   <= '0;
         for (int i = 0; i < NUM_SRC; i++) mailbox[i] <= 8'h00;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]) begin
               mailbox[i]     <= src_data[8*i +: 8];
               src_pending[i] <= 1'b1;
               if (src_pending[i]) overwrite[i] <= 1'b1;
            end else if (grant_fire && (grant == PTR_W'(i))) begin
               src_pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_data <= 8'h00;
         tx_data    <= 8'h00;
         rr_ptr     <= '0;
         ack_cnt    <= '0;
         ack_error  <= 1'b0;
      end else begin
         if (grant_fire) begin
            frame_data <= mailbox[grant];
            tx_data    <= {4'hA, 4'(grant)};
            rr_ptr     <= rr_next;
         end
         if (load_payload) tx_data <= frame_data;
         if (state == H_ACK || state == P_ACK) ack_cnt <= ack_cnt + 1'b1;
         else                                  ack_cnt <= '0;
         if (ack_timeout) ack_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized rounds checked
// against a queue-based round-robin reference model.
module tb_uart_tx_scheduler;

   localparam int NUM_SRC     = 3;
   localparam int ACK_TIMEOUT = 16;
   localparam int BUSY_LEN    = 10;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic [NUM_SRC-1:0]     src_valid = '0;
   logic [8*NUM_SRC-1:0]   src_data = '0;
   logic [NUM_SRC-1:0]     src_pending;
   logic                   tx_busy = 1'b0;
   logic                   tx_start;
   logic [7:0]             tx_data;
   logic                   sched_busy;
   logic                   frame_done;
   logic [NUM_SRC-1:0]     overwrite;
   logic                   ack_error;

   logic                   no_ack = 1'b0;
   int                     busy_cnt = 0;
   logic [7:0]             last_byte = 8'h00;
   logic [7:0]             sent_q[$];
   logic [7:0]             exp_q[$];
   int                     fd_cnt = 0;
   int                     ts_cnt = 0;
   int                     stab_err = 0;

   int                     n_assert = 0;
   int                     n_fail = 0;

   always #5 clock = ~clock;

   uart_tx_scheduler #(.NUM_SRC(NUM_SRC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clock       (clock),
      .reset       (reset),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_pending (src_pending),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .sched_busy  (sched_busy),
      .frame_done  (frame_done),
      .overwrite   (overwrite),
      .ack_error   (ack_error)
   );

   // uart_tx stand-in: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
   always @(posedge clock) begin
      if (tx_start)   ts_cnt <= ts_cnt + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (tx_busy && tx_data !== last_byte) stab_err <= stab_err + 1;
      if (reset) begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (tx_start && !no_ack) begin
         sent_q.push_back(tx_data);
         last_byte <= tx_data;
         busy_cnt  <= BUSY_LEN;
         tx_busy   <= 1'b1;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         tx_busy  <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      src_valid = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse(input logic [NUM_SRC-1:0] m, input logic [8*NUM_SRC-1:0] d);
      src_valid = m;
      src_data  = d;
      tick();
      src_valid = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!(sched_busy == 1'b0 && src_pending == '0 && tx_busy == 1'b0) && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_idle_bound"}, 64'(n < 3000), 64'd1);
   endtask

   task automatic wait_fd(input string tag);
      int n = 0;
      while (frame_done !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      check({tag, "_fd_bound"}, 64'(n < 500), 64'd1);
   endtask

   task automatic check_sent(input string tag, input int base);
      check({tag, "_nbytes"}, 64'(sent_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < sent_q.size())
            check($sformatf("%s_byte%0d", tag, i), 64'(sent_q[base + i]), 64'(exp_q[i]));
      end
   endtask

   initial begin
      int base;
      int fd0;
      int ts0;
      int n;
      int k;
      int ref_rr;
      int last;
      int nbits;
      logic [NUM_SRC-1:0] mask;
      logic [31:0]        d;
      logic [7:0]         h;

      // Reset state
      tick();
      tick();
      check("rst_tx_start", 64'(tx_start), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_sched_busy", 64'(sched_busy), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_pending", 64'(src_pending), 64'd0);
      check("rst_overwrite", 64'(overwrite), 64'd0);
      check("rst_ack_error", 64'(ack_error), 64'd0);
      reset = 1'b0;

      // 1: single source frame and header latency
      base = sent_q.size();
      fd0  = fd_cnt;
      pulse(3'b001, 24'h000004);
      check("t1_pending_set", 64'(src_pending), 64'h1);
      check("t1_no_start_yet", 64'(tx_start), 64'd0);
      tick();
      check("t1_hdr_start", 64'(tx_start), 64'd1);
      check("t1_hdr_data", 64'(tx_data), 64'hA0);
      check("t1_sched_busy", 64'(sched_busy), 64'd1);
      tick();
      check("t1_start_one_cycle", 64'(tx_start), 64'd0);
      wait_idle("t1");
      exp_q = '{8'hA0, 8'h04};
      check_sent("t1", base);
      check("t1_fd_count", 64'(fd_cnt - fd0), 64'd1);
      check("t1_pending_clear", 64'(src_pending), 64'd0);
      check("t1_tx_data_hold", 64'(tx_data), 64'h04);

      // 2: three simultaneous sources served in order
      do_reset();
      base = sent_q.size();
      fd0  = fd_cnt;
      pulse(3'b111, 24'h332211);
      check("t2_pending_all", 64'(src_pending), 64'h7);
      wait_fd("t2a");
      check("t2_pending_after1", 64'(src_pending), 64'h6);
      tick();
      wait_fd("t2b");
      check("t2_pending_after2", 64'(src_pending), 64'h4);
      tick();
      wait_fd("t2c");
      check("t2_pending_after3", 64'(src_pending), 64'h0);
      wait_idle("t2");
      exp_q = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33};
      check_sent("t2", base);
      check("t2_fd_count", 64'(fd_cnt - fd0), 64'd3);

      // 3: overwrite while a frame is in flight
      do_reset();
      base = sent_q.size();
      pulse(3'b001, 24'h000044);
      tick();
      tick();
      tick();
      pulse(3'b001, 24'h000055);
      check("t3_no_overwrite_yet", 64'(overwrite), 64'd0);
      pulse(3'b001, 24'h000066);
      check("t3_overwrite_set", 64'(overwrite), 64'h1);
      wait_idle("t3");
      exp_q = '{8'hA0, 8'h44, 8'hA0, 8'h66};
      check_sent("t3", base);
      check("t3_overwrite_sticky", 64'(overwrite), 64'h1);

      // 4: src0 and src2 refilled every cycle must alternate
      do_reset();
      base = sent_q.size();
      fd0  = fd_cnt;
      for (int c = 0; c < 300; c++) begin
         src_valid = 3'b101;
         src_data  = {8'(c + 128), 8'h00, 8'(c)};
         tick();
      end
      src_valid = '0;
      wait_idle("t4");
      n = (sent_q.size() - base) / 2;
      check("t4_enough_frames", 64'(n >= 8), 64'd1);
      check("t4_fd_count", 64'(fd_cnt - fd0), 64'(n));
      k = 0;
      for (int i = base; i + 1 < sent_q.size(); i += 2) begin
         h = sent_q[i];
         check($sformatf("t4_hdr%0d", k), 64'(h), (k % 2 == 0) ? 64'hA0 : 64'hA2);
         k++;
      end

      // 5: uart never acknowledges
      do_reset();
      no_ack = 1'b1;
      ts0 = ts_cnt;
      pulse(3'b010, 24'h00BB00);
      tick();
      check("t5_hdr_start", 64'(tx_start), 64'd1);
      n = 0;
      while (ack_error !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("t5_ack_latency", 64'(n), 64'(ACK_TIMEOUT + 1));
      check("t5_back_idle", 64'(sched_busy), 64'd0);
      check("t5_pending_dropped", 64'(src_pending), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      check("t5_one_start", 64'(ts_cnt - ts0), 64'd1);
      check("t5_ack_sticky", 64'(ack_error), 64'd1);
      no_ack = 1'b0;

      // 6: reset while the payload byte is in flight
      do_reset();
      fd0 = fd_cnt;
      pulse(3'b100, 24'h770000);
      n = 0;
      while (!(tx_start === 1'b1 && tx_data === 8'h77) && n < 200) begin
         tick();
         n++;
      end
      check("t6_payload_bound", 64'(n < 200), 64'd1);
      tick();
      tick();
      check("t6_in_p_done", 64'({sched_busy, tx_busy}), 64'h3);
      reset = 1'b1;
      tick();
      check("t6_tx_start", 64'(tx_start), 64'd0);
      check("t6_tx_data", 64'(tx_data), 64'd0);
      check("t6_sched_busy", 64'(sched_busy), 64'd0);
      check("t6_frame_done", 64'(frame_done), 64'd0);
      check("t6_pending", 64'(src_pending), 64'd0);
      check("t6_ack_error", 64'(ack_error), 64'd0);
      reset = 1'b0;
      tick();
      base = sent_q.size();
      pulse(3'b010, 24'h005A00);
      wait_idle("t6");
      exp_q = '{8'hA1, 8'h5A};
      check_sent("t6", base);
      check("t6_fd_count", 64'(fd_cnt - fd0), 64'd1);

      // Random rounds against a round-robin reference
      do_reset();
      ref_rr = 0;
      for (int r = 0; r < 12; r++) begin
         mask = 3'($urandom_range(1, 7));
         d    = $urandom;
         base = sent_q.size();
         fd0  = fd_cnt;
         pulse(mask, d[23:0]);
         wait_idle($sformatf("rnd%0d", r));
         exp_q.delete();
         last  = ref_rr;
         nbits = 0;
         for (int j = 0; j < NUM_SRC; j++) begin
            int idx;
            idx = (ref_rr + j) % NUM_SRC;
            if (mask[idx]) begin
               exp_q.push_back({4'hA, 4'(idx)});
               exp_q.push_back(d[8*idx +: 8]);
               last = idx;
               nbits++;
            end
         end
         ref_rr = (last + 1) % NUM_SRC;
         check_sent($sformatf("rnd%0d", r), base);
         check($sformatf("rnd%0d_fd", r), 64'(fd_cnt - fd0), 64'(nbits));
      end

      check("tx_data_stable_while_busy", 64'(stab_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
